// File: rtl/aes_reverse_key_scheduler_if.sv
// Key-load / round-key handshake bundle for the AES-128 reverse key scheduler.
// Carries load_is_last only when LAST_KEY_LOAD_EN is defined.
interface aes_reverse_key_scheduler_if;
    logic         key_load;
    logic [127:0] key_in;
    logic         rk_ready;
    logic         rk_valid;
    logic [127:0] rk_out;
    logic [3:0]   rk_round;
    logic         busy;
`ifdef LAST_KEY_LOAD_EN
    logic         load_is_last;
`endif

    modport master (
`ifdef LAST_KEY_LOAD_EN
        output load_is_last,
`endif
        output key_load, key_in, rk_ready,
        input  rk_valid, rk_out, rk_round, busy
    );

    modport slave (
`ifdef LAST_KEY_LOAD_EN
        input  load_is_last,
`endif
        input  key_load, key_in, rk_ready,
        output rk_valid, rk_out, rk_round, busy
    );
endinterface

// File: rtl/aes_reverse_key_scheduler.sv
// AES-128 on-the-fly reverse key scheduler: expands to round 10, then serves keys 10..0.
// Optional LAST_KEY_LOAD_EN: load_is_last loads key_in directly as the round-10 key.

module SBox (
    input  logic [7:0] addr,
    output logic [7:0] dout
);
    localparam logic [0:2047] SboxTable = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign dout = SboxTable[{addr, 3'b000} +: 8];
endmodule

module aes_reverse_key_scheduler #(
    parameter int unsigned NR = 10
) (
    input logic                        clk,
    input logic                        reset,
    aes_reverse_key_scheduler_if.slave bus
);
    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StExpand = 2'd1;
    localparam logic [1:0] StServe  = 2'd2;

    logic [1:0]   state_q;
    logic [3:0]   cnt_q;
    logic [127:0] key_q;
    logic         valid_q;

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  sbox_in, rot_word, sub_word, g_word;
    logic [3:0]   rcon_idx;
    logic [7:0]   rcon;
    logic [31:0]  f0, f1, f2, f3;
    logic [31:0]  i0, i1, i2, i3;
    logic         accept;
    logic         load_last;

    assign {w0, w1, w2, w3} = key_q;

    // In SERVE the previous w3 is recovered as w3'^w2' before substitution.
    assign sbox_in  = (state_q == StServe) ? (w3 ^ w2) : w3;
    assign rot_word = {sbox_in[23:0], sbox_in[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        SBox u_sbox (
            .addr(rot_word[8*i +: 8]),
            .dout(sub_word[8*i +: 8])
        );
    end

    assign rcon_idx = (state_q == StServe) ? cnt_q : cnt_q + 4'd1;

    always_comb begin
        rcon = 8'h00;
        case (rcon_idx)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign g_word = sub_word ^ {rcon, 24'h000000};

    assign f0 = w0 ^ g_word;
    assign f1 = w1 ^ f0;
    assign f2 = w2 ^ f1;
    assign f3 = w3 ^ f2;

    assign i3 = w3 ^ w2;
    assign i2 = w2 ^ w1;
    assign i1 = w1 ^ w0;
    assign i0 = w0 ^ g_word;

    assign accept = valid_q && bus.rk_ready;

`ifdef LAST_KEY_LOAD_EN
    assign load_last = bus.load_is_last;
`else
    assign load_last = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            key_q   <= 128'h0;
            valid_q <= 1'b0;
        end else if (bus.key_load) begin
            key_q <= bus.key_in;
            if (load_last) begin
                cnt_q   <= NR[3:0];
                state_q <= StServe;
                valid_q <= 1'b1;
            end else begin
                cnt_q   <= 4'd0;
                state_q <= StExpand;
                valid_q <= 1'b0;
            end
        end else begin
            case (state_q)
                StExpand: begin
                    key_q <= {f0, f1, f2, f3};
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q + 4'd1 == NR[3:0]) begin
                        state_q <= StServe;
                        valid_q <= 1'b1;
                    end
                end
                StServe: begin
                    if (accept) begin
                        if (cnt_q != 4'd0) begin
                            key_q <= {i0, i1, i2, i3};
                            cnt_q <= cnt_q - 4'd1;
                        end else begin
                            state_q <= StIdle;
                            valid_q <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs are masked outside SERVE so no intermediate key leaks.
    assign bus.rk_valid = valid_q;
    assign bus.rk_out   = valid_q ? key_q : 128'h0;
    assign bus.rk_round = valid_q ? cnt_q : 4'd0;
    assign bus.busy     = (state_q != StIdle);
endmodule

// File: tb/tb_aes_reverse_key_scheduler.sv
// Scoreboard bench for aes_reverse_key_scheduler using FIPS-197 key-schedule vectors.
module tb_aes_reverse_key_scheduler;
    logic clk = 1'b0;
    logic reset;

    aes_reverse_key_scheduler_if bus ();

    aes_reverse_key_scheduler #(.NR(10)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [131:0] exp_q[$];
    logic [127:0] rk_a[0:10];

    logic         hold_prev = 1'b0;
    logic [127:0] prev_out;
    logic [3:0]   prev_round;
    logic         exp_idle = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push_range(input int hi, input int lo);
        for (int r = hi; r >= lo; r--) exp_q.push_back({4'(r), rk_a[r]});
    endtask

    task automatic load_key(input logic [127:0] k);
        bus.key_in   = k;
        bus.key_load = 1'b1;
        @(posedge clk);
        #1 bus.key_load = 1'b0;
    endtask

    task automatic wait_valid(input int exp_n, input string name);
        int n = 0;
        while (!bus.rk_valid && n < 40) begin
            @(posedge clk);
            #1 n++;
        end
        check(name, n, exp_n);
        check({name, "_round"}, bus.rk_round, 4'd10);
    endtask

    task automatic wait_idle(input int max_c, input string name);
        int n = 0;
        while (bus.busy && n < max_c) begin
            @(posedge clk);
            #1 n++;
        end
        check(name, bus.busy, 1'b0);
    endtask

    task automatic check_zero(input string name);
        check({name, "_valid"}, bus.rk_valid, 1'b0);
        check({name, "_out"}, bus.rk_out, 128'h0);
        check({name, "_round"}, bus.rk_round, 4'd0);
        check({name, "_busy"}, bus.busy, 1'b0);
    endtask

    // Monitor: pops the scoreboard on every accepted transfer, checks hold stability.
    initial begin : monitor
        logic [131:0] e;
        forever begin
            @(negedge clk);
            if (exp_idle) begin
                check("idle_after_r0", bus.rk_valid, 1'b0);
                exp_idle = 1'b0;
            end
            if (hold_prev && bus.rk_valid) begin
                check("hold_out", bus.rk_out, prev_out);
                check("hold_round", bus.rk_round, prev_round);
            end
            if (bus.rk_valid && bus.rk_ready && !reset) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_key: got round %0d key %h, expected none",
                             bus.rk_round, bus.rk_out);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_round", bus.rk_round, e[131:128]);
                    check("sb_key", bus.rk_out, e[127:0]);
                    if (e[131:128] == 4'd0 && !bus.key_load) exp_idle = 1'b1;
                end
            end
            hold_prev  = bus.rk_valid && !bus.rk_ready && !reset && !bus.key_load;
            prev_out   = bus.rk_out;
            prev_round = bus.rk_round;
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

    initial begin : stimulus
        int i;
        rk_a[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        rk_a[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        rk_a[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        rk_a[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        rk_a[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        rk_a[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        rk_a[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        rk_a[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        rk_a[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        rk_a[9]  = 128'hac7766f319fadc2128d12941575c006e;
        rk_a[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        reset        = 1'b1;
        bus.key_load = 1'b0;
        bus.key_in   = 128'h0;
        bus.rk_ready = 1'b0;
`ifdef LAST_KEY_LOAD_EN
        bus.load_is_last = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (5) @(posedge clk);
        #1 check_zero("reset_idle");

        // Continuous ready: 11 keys back to back.
        bus.rk_ready = 1'b1;
        push_range(10, 0);
        load_key(rk_a[0]);
        wait_valid(10, "t1_latency");
        check("t1_rk10", bus.rk_out, rk_a[10]);
        wait_idle(40, "t1_done");
        check("t1_queue", exp_q.size(), 0);

        // Random ready: same accepted sequence, held values while stalled.
        push_range(10, 0);
        load_key(rk_a[0]);
        i = 0;
        while (bus.busy && i < 400) begin
            bus.rk_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1 i++;
        end
        check("t2_done", bus.busy, 1'b0);
        check("t2_queue", exp_q.size(), 0);

        // Abort with a new key while serving round 6.
        bus.rk_ready = 1'b1;
        push_range(10, 7);
        load_key(rk_a[0]);
        wait_valid(10, "t3_latency");
        i = 0;
        while (!(bus.rk_valid && bus.rk_round == 4'd6) && i < 20) begin
            @(posedge clk);
            #1 i++;
        end
        check("t3_at6", bus.rk_round, 4'd6);
        bus.rk_ready = 1'b0;
        load_key(128'h000102030405060708090a0b0c0d0e0f);
        check("t3_drop", bus.rk_valid, 1'b0);
        exp_q.push_back({4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5});
        wait_valid(10, "t3_new_latency");
        check("t3_new_rk10", bus.rk_out, 128'h13111d7fe3944a17f307a78b4d2b30c5);
        bus.rk_ready = 1'b1;
        @(posedge clk);
        #1 bus.rk_ready = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        check_zero("t3_serve_reset");
        check("t3_queue", exp_q.size(), 0);

        // Reset during EXPAND at cnt=4, then a normal load.
        load_key(rk_a[0]);
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        check_zero("t4_expand_reset");
        bus.rk_ready = 1'b1;
        push_range(10, 0);
        load_key(rk_a[0]);
        wait_valid(10, "t4_latency");
        wait_idle(40, "t4_done");
        check("t4_queue", exp_q.size(), 0);

`ifdef LAST_KEY_LOAD_EN
        // Direct round-10 load walks down to the cipher key.
        push_range(10, 0);
        bus.key_in       = rk_a[10];
        bus.load_is_last = 1'b1;
        bus.key_load     = 1'b1;
        @(posedge clk);
        #1 bus.key_load  = 1'b0;
        bus.load_is_last = 1'b0;
        wait_valid(0, "t5_latency");
        wait_idle(40, "t5_done");
        check("t5_queue", exp_q.size(), 0);
`endif

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
